// File: rtl/msg_byte_router_pkg.sv
// Shared types and constants for msg_byte_router: state encoding, sync marker,
// count/ID widths and the checksum helper used when MSG_ROUTER_CHECKSUM_EN is defined.
package msg_byte_router_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CNT_W         = 8;
  localparam int         NUM_SINKS_DEF = 4;
  localparam int         ID_W_DEF      = 2;

  // Port width for a sink index; a single sink still needs one bit.
  function automatic int id_width(input int num_sinks);
    return (num_sinks > 1) ? $clog2(num_sinks) : 1;
  endfunction

`ifdef MSG_ROUTER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_ID  = 3'd1,
    ST_GET_LEN = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_GET_SUM = 3'd4
  } state_e;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_ID  = 3'd1,
    ST_GET_LEN = 3'd2,
    ST_PAYLOAD = 3'd3
  } state_e;
`endif

endpackage

// File: rtl/msg_byte_router_timeout.sv
// msg_timeout_counter: counts idle cycles while enabled; expired pulses on the
// TIMEOUT_CYCLES-th consecutive enabled cycle without a clear.
module msg_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  assign expired = enable && !clear && (count_q == LAST);

  // Next idle-cycle count
  always_comb begin
    count_d = count_q;
    if (clear || !enable) begin
      count_d = '0;
    end else if (expired) begin
      count_d = '0;
    end else begin
      count_d = count_q + TW'(1);
    end
  end

  // Idle-cycle count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/msg_byte_router.sv
// Frame parser routing payload bytes to one of NUM_SINKS assembly sinks.
// Optional trailing checksum byte enabled by defining MSG_ROUTER_CHECKSUM_EN.
module msg_byte_router
  import msg_byte_router_pkg::*;
#(
  parameter int         NUM_SINKS      = NUM_SINKS_DEF,
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 50000,
  localparam int        ID_W           = id_width(NUM_SINKS)
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [7:0]           ByteIn,
  input  logic                 ByteReady,
  output logic [7:0]           DataByte,
  output logic [NUM_SINKS-1:0] ClearAddr,
  output logic [NUM_SINKS-1:0] WriteByte,
  output logic                 MsgDone,
  output logic                 MsgError,
  output logic [ID_W-1:0]      MsgId,
  output logic                 Busy
);

  localparam logic [8:0] NUM_SINKS_9 = 9'(NUM_SINKS);
  localparam logic [8:0] MAX_LEN_9   = 9'(MAX_LEN);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           data_q, data_d;
  logic [NUM_SINKS-1:0] clear_q, clear_d;
  logic [NUM_SINKS-1:0] write_q, write_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 tmo_expired;
`ifdef MSG_ROUTER_CHECKSUM_EN
  logic [7:0]           sum_q, sum_d;
`endif

  msg_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .clear  (ByteReady),
    .enable (state_q != ST_IDLE),
    .expired(tmo_expired)
  );

  // Frame FSM: next state, counters and one-cycle strobes
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    clear_d = '0;
    write_d = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef MSG_ROUTER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (tmo_expired) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (ByteReady) begin
      case (state_q)
        ST_IDLE: begin
          if (ByteIn == SYNC_BYTE) begin
            state_d = ST_GET_ID;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_GET_ID: begin
          if ({1'b0, ByteIn} < NUM_SINKS_9) begin
            id_d                       = ByteIn[ID_W-1:0];
            clear_d[ByteIn[ID_W-1:0]]  = 1'b1;
            state_d                    = ST_GET_LEN;
`ifdef MSG_ROUTER_CHECKSUM_EN
            sum_d                      = ByteIn;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_GET_LEN: begin
`ifdef MSG_ROUTER_CHECKSUM_EN
          sum_d = sum8(sum_q, ByteIn);
`endif
          if ({1'b0, ByteIn} > MAX_LEN_9) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (ByteIn == 8'd0) begin
`ifdef MSG_ROUTER_CHECKSUM_EN
            state_d = ST_GET_SUM;
`else
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end else begin
            cnt_d   = ByteIn;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          data_d        = ByteIn;
          write_d[id_q] = 1'b1;
          cnt_d         = cnt_q - 8'd1;
`ifdef MSG_ROUTER_CHECKSUM_EN
          sum_d         = sum8(sum_q, ByteIn);
`endif
          if (cnt_q == 8'd1) begin
`ifdef MSG_ROUTER_CHECKSUM_EN
            state_d = ST_GET_SUM;
`else
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
`ifdef MSG_ROUTER_CHECKSUM_EN
        ST_GET_SUM: begin
          if (ByteIn == sum_q) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, data and strobe registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      clear_q <= '0;
      write_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MSG_ROUTER_CHECKSUM_EN
      sum_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      clear_q <= clear_d;
      write_q <= write_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef MSG_ROUTER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign DataByte  = data_q;
  assign ClearAddr = clear_q;
  assign WriteByte = write_q;
  assign MsgDone   = done_q;
  assign MsgError  = err_q;
  assign MsgId     = id_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_msg_byte_router.sv
// Directed self-checking bench for msg_byte_router (NUM_SINKS=4, MAX_LEN=16,
// short timeout); checksum frames are exercised when MSG_ROUTER_CHECKSUM_EN is defined.
module tb_msg_byte_router;

  localparam int T = 20;

  logic       Clock;
  logic       Reset_n;
  logic [7:0] ByteIn;
  logic       ByteReady;
  logic [7:0] DataByte;
  logic [3:0] ClearAddr;
  logic [3:0] WriteByte;
  logic       MsgDone;
  logic       MsgError;
  logic [1:0] MsgId;
  logic       Busy;

  int total = 0;
  int bad   = 0;

  msg_byte_router #(
    .NUM_SINKS     (4),
    .MAX_LEN       (16),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .ByteIn   (ByteIn),
    .ByteReady(ByteReady),
    .DataByte (DataByte),
    .ClearAddr(ClearAddr),
    .WriteByte(WriteByte),
    .MsgDone  (MsgDone),
    .MsgError (MsgError),
    .MsgId    (MsgId),
    .Busy     (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [15:0] pk(input logic busy, input logic err, input logic done,
                                     input logic [3:0] wr, input logic [3:0] clr);
    return {5'd0, busy, err, done, wr, clr};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] b, input string tag,
                      input logic [15:0] exp_v);
    ByteReady = r;
    ByteIn    = b;
    @(posedge Clock);
    #1;
    chk(tag, {5'd0, Busy, MsgError, MsgDone, WriteByte, ClearAddr}, exp_v);
  endtask

  initial begin
    Reset_n   = 1'b0;
    ByteReady = 1'b0;
    ByteIn    = 8'h00;
    #2;
    chk("rst_strobes", {5'd0, Busy, MsgError, MsgDone, WriteByte, ClearAddr}, 16'h0000);
    chk("rst_data", {8'h00, DataByte}, 16'h0000);
    chk("rst_id", {14'd0, MsgId}, 16'h0000);
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    step(1'b0, 8'h00, "idle0", pk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));

    // Frame to sink 1 with four payload bytes
    step(1'b1, 8'hA5, "a_sync", pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'h01, "a_id",   pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010));
    step(1'b1, 8'h04, "a_len",  pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'h11, "a_p0",   pk(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000));
    chk("a_d0", {8'h00, DataByte}, 16'h0011);
    step(1'b1, 8'h22, "a_p1",   pk(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000));
    chk("a_d1", {8'h00, DataByte}, 16'h0022);
    step(1'b1, 8'h33, "a_p2",   pk(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000));
    chk("a_d2", {8'h00, DataByte}, 16'h0033);
`ifdef MSG_ROUTER_CHECKSUM_EN
    step(1'b1, 8'h44, "a_p3",   pk(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000));
    chk("a_d3", {8'h00, DataByte}, 16'h0044);
    step(1'b1, 8'hAF, "a_sum",  pk(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000));
`else
    step(1'b1, 8'h44, "a_p3",   pk(1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000));
    chk("a_d3", {8'h00, DataByte}, 16'h0044);
`endif
    chk("a_id_out", {14'd0, MsgId}, 16'h0001);

    // Bad ID, back to back with the previous frame
    step(1'b1, 8'hA5, "b_sync", pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'h07, "b_id",   pk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'h03, "b_junk", pk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));

    // Sync value inside payload is plain data
    step(1'b1, 8'hA5, "c_sync", pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'h02, "c_id",   pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100));
    step(1'b1, 8'h02, "c_len",  pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'hA5, "c_p0",   pk(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000));
    chk("c_d0", {8'h00, DataByte}, 16'h00A5);
`ifdef MSG_ROUTER_CHECKSUM_EN
    step(1'b1, 8'h5A, "c_p1",   pk(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000));
    step(1'b1, 8'h03, "c_sum",  pk(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000));
`else
    step(1'b1, 8'h5A, "c_p1",   pk(1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000));
`endif
    chk("c_d1", {8'h00, DataByte}, 16'h005A);
    chk("c_id_out", {14'd0, MsgId}, 16'h0002);

    // Zero-length frame
    step(1'b1, 8'hA5, "z_sync", pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'h00, "z_id",   pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001));
`ifdef MSG_ROUTER_CHECKSUM_EN
    step(1'b1, 8'h00, "z_len",  pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'h00, "z_sum",  pk(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000));
`else
    step(1'b1, 8'h00, "z_len",  pk(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000));
`endif
    chk("z_id_out", {14'd0, MsgId}, 16'h0000);

`ifdef MSG_ROUTER_CHECKSUM_EN
    // Checksum mismatch
    step(1'b1, 8'hA5, "s_sync", pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'h02, "s_id",   pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100));
    step(1'b1, 8'h01, "s_len",  pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'hFF, "s_p0",   pk(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000));
    step(1'b1, 8'h03, "s_sum",  pk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));
`endif

    // Length one over the limit
    step(1'b1, 8'hA5, "l_sync", pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'h03, "l_id",   pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000));
    step(1'b1, 8'h11, "l_len",  pk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));

    // Reset in the middle of a frame
    step(1'b1, 8'hA5, "r_sync", pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'h03, "r_id",   pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000));
    step(1'b1, 8'h10, "r_len",  pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'hAA, "r_p0",   pk(1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000));
    ByteReady = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("r_async", {5'd0, Busy, MsgError, MsgDone, WriteByte, ClearAddr}, 16'h0000);
    chk("r_data", {8'h00, DataByte}, 16'h0000);
    chk("r_id_out", {14'd0, MsgId}, 16'h0000);
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    step(1'b0, 8'h00, "r_idle", pk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'hBB, "r_drop", pk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));

    // Timeout inside a frame
    step(1'b1, 8'hA5, "t_sync", pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'h00, "t_id",   pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001));
    step(1'b1, 8'h02, "t_len",  pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step(1'b1, 8'hAA, "t_p0",   pk(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000));
    for (int i = 1; i < T; i++) begin
      step(1'b0, 8'h00, "t_wait", pk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
    end
    step(1'b0, 8'h00, "t_err",  pk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));
    step(1'b0, 8'h00, "t_idle", pk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
